// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, state encoding and helpers for input debouncing
//
// Purpose : common definitions for the push-button debouncer and the switch
//           conditioning that will reuse the same synchroniser.
// Contents: CLK_FREQ_HZ / DEBOUNCE_20MS default qualification time,
//           db_state_e FSM encoding, cnt_width() counter-width helper.
package debounce_pkg;

   localparam int CLK_FREQ_HZ   = 50_000_000;
   // 20 ms worth of clk cycles; 1,000,000 at 50 MHz.
   localparam int DEBOUNCE_20MS = CLK_FREQ_HZ / 50;

   localparam logic [1:0] IDLE_LO_ENC = 2'd0;
   localparam logic [1:0] WAIT_HI_ENC = 2'd1;
   localparam logic [1:0] IDLE_HI_ENC = 2'd2;
   localparam logic [1:0] WAIT_LO_ENC = 2'd3;

   typedef enum logic [1:0] {
      IDLE_LO = IDLE_LO_ENC,
      WAIT_HI = WAIT_HI_ENC,
      IDLE_HI = IDLE_HI_ENC,
      WAIT_LO = WAIT_LO_ENC
   } db_state_e;

   // The counter only has to hold 0..n-1, so $clog2(n) bits suffice.
   // Clamped to 1 so an illegal n still elaborates far enough to report it.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_debouncer_sync2.sv
// rtl/button_debouncer_sync2.sv - generic two-flop synchroniser
//
// Purpose : brings an asynchronous level into the clk domain.
// Ports   : clk    - destination clock
//           rst_n  - synchronous active-low reset, loads RESET_VAL
//           d_i    - asynchronous input
//           q_o    - synchronised output (two clk edges of latency)
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
      end
   end

   assign q_o = sync2_q;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button synchroniser, debouncer and press/release strobes
//
// Purpose : turns a raw bouncing KEY pad into a clean level plus one-cycle
//           press/release strobes. A level change commits only after
//           STABLE_CYCLES consecutive agreeing synchronised samples.
// Ports   : clk         - system clock
//           rst_n       - synchronous active-low reset
//           btn_raw     - raw pad, asynchronous to clk
//           btn_level   - debounced level, 1 = pressed
//           btn_press   - one-cycle strobe on committed 0->1
//           btn_release - one-cycle strobe on committed 1->0
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_20MS,
   parameter bit INVERT        = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   generate
      if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
         $error("button_debouncer: STABLE_CYCLES must be >= 2");
      end
   endgenerate

   logic             btn_in;
   logic             samp;
   db_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             press_q;
   logic             release_q;

   // Active-low KEYs are flipped here so everything downstream is 1 = pressed.
   assign btn_in = btn_raw ^ INVERT;

   // Resetting the synchroniser to 0 means "released", so a held-released
   // KEY cannot qualify a press straight out of reset.
   sync2 #(
      .RESET_VAL (1'b0)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (btn_in),
      .q_o   (samp)
   );

   // Only reached while cnt_q < CNT_LAST, so this never wraps.
   assign cnt_d = cnt_q + CNT_ONE;

   // The mismatch test comes before the commit test in each WAIT state, so a
   // glitch on the would-be commit sample cancels the commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE_LO;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            IDLE_LO: begin
               if (samp) begin
                  state_q <= WAIT_HI;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            WAIT_HI: begin
               if (!samp) begin
                  state_q <= IDLE_LO;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE_HI;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
               end else begin
                  cnt_q   <= cnt_d;
               end
            end
            IDLE_HI: begin
               if (!samp) begin
                  state_q <= WAIT_LO;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            WAIT_LO: begin
               if (samp) begin
                  state_q <= IDLE_HI;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= IDLE_LO;
                  cnt_q     <= '0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  cnt_q     <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE_LO;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer (two configurations)
module tb_button_debouncer;

   localparam int S0 = 4;
   localparam int S1 = 2;
   localparam int SC  [2] = '{S0, S1};
   localparam bit INV [2] = '{1'b1, 1'b0};

   logic clk;
   logic rstn  [2];
   logic raw   [2];
   logic level [2];
   logic press [2];
   logic rel   [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model state: a delay line of pad samples and a run length of
   // samples disagreeing with the current level.
   logic d1   [2];
   logic d2   [2];
   int   run  [2];
   logic mlvl [2];
   // Expected strobe events, encoded as cycle*2 + new_level.
   int   q0 [$];
   int   q1 [$];

   button_debouncer #(.STABLE_CYCLES(S0), .INVERT(1'b1)) u_dut_a (
      .clk         (clk),
      .rst_n       (rstn[0]),
      .btn_raw     (raw[0]),
      .btn_level   (level[0]),
      .btn_press   (press[0]),
      .btn_release (rel[0])
   );

   button_debouncer #(.STABLE_CYCLES(S1), .INVERT(1'b0)) u_dut_b (
      .clk         (clk),
      .rst_n       (rstn[1]),
      .btn_raw     (raw[1]),
      .btn_level   (level[1]),
      .btn_press   (press[1]),
      .btn_release (rel[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int id, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s dut%0d cycle=%0d actual=%0d expected=%0d", name, id, cyc, act, exp);
      end
   endtask

   task automatic push_ev(input int id, input int ev);
      if (id == 0) q0.push_back(ev);
      else         q1.push_back(ev);
   endtask

   function automatic int qsize(input int id);
      return (id == 0) ? q0.size() : q1.size();
   endfunction

   function automatic int qfront(input int id);
      return (id == 0) ? q0[0] : q1[0];
   endfunction

   task automatic qpop(input int id);
      if (id == 0) void'(q0.pop_front());
      else         void'(q1.pop_front());
   endtask

   // Level flips once STABLE_CYCLES consecutive samples (seen two edges after
   // the pad) disagree with it; any agreeing sample resets the run.
   task automatic model_step(input int id);
      logic s;
      if (!rstn[id]) begin
         d1[id] = 1'b0; d2[id] = 1'b0; run[id] = 0; mlvl[id] = 1'b0;
      end else begin
         s      = d2[id];
         d2[id] = d1[id];
         d1[id] = raw[id] ^ INV[id];
         run[id] = (s != mlvl[id]) ? run[id] + 1 : 0;
         if (run[id] == SC[id]) begin
            mlvl[id] = s;
            run[id]  = 0;
            push_ev(id, cyc * 2 + int'(s));
         end
      end
   endtask

   task automatic mon_step(input int id);
      int ev;
      check("level", id, int'(level[id]), int'(mlvl[id]));
      if (press[id] && rel[id]) check("both_strobes", id, 1, 0);
      if (press[id] || rel[id]) begin
         if (qsize(id) == 0) begin
            check("spurious_strobe", id, int'(press[id]) * 2 + int'(rel[id]), 0);
         end else begin
            ev = qfront(id);
            qpop(id);
            check("strobe_cycle", id, cyc, ev / 2);
            check("strobe_is_press", id, int'(press[id]), ev % 2);
         end
      end else if (qsize(id) != 0 && qfront(id) / 2 <= cyc) begin
         check("missed_strobe_cycle", id, -1, qfront(id) / 2);
         qpop(id);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      mon_step(0);
      mon_step(1);
   end

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic outs(input string name, input int id, input int lv, input int pr, input int rl);
      check({name, "_level"}, id, int'(level[id]), lv);
      check({name, "_press"}, id, int'(press[id]), pr);
      check({name, "_release"}, id, int'(rel[id]), rl);
   endtask

   task automatic random_run(input int id, input int n);
      for (int i = 0; i < n; i++) begin
         raw[id] = ~raw[id];
         nclk($urandom_range(1, 2 * SC[id] - 1));
         if ($urandom_range(0, 15) == 0) begin
            rstn[id] = 1'b0;
            nclk(1);
            rstn[id] = 1'b1;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         d1[i] = 1'b0; d2[i] = 1'b0; run[i] = 0; mlvl[i] = 1'b0;
      end
      rstn[0] = 1'b0; rstn[1] = 1'b0;
      raw[0]  = 1'b1; raw[1]  = 1'b0;
      nclk(10);
      outs("reset", 0, 0, 0, 0);
      outs("reset", 1, 0, 0, 0);
      rstn[0] = 1'b1; rstn[1] = 1'b1;
      nclk(10);
      outs("released_idle", 0, 0, 0, 0);

      // Press: commit at posedge k+5.
      raw[0] = 1'b0;
      nclk(5);
      outs("press_early", 0, 0, 0, 0);
      nclk(1);
      outs("press_commit", 0, 1, 1, 0);
      nclk(1);
      outs("press_after", 0, 1, 0, 0);

      // Release: commit five edges after the pad rises.
      raw[0] = 1'b1;
      nclk(6);
      outs("release_commit", 0, 0, 0, 1);
      nclk(1);
      outs("release_after", 0, 0, 0, 0);
      nclk(4);

      // Bounce shorter than the qualification window.
      raw[0] = 1'b0; nclk(3);
      raw[0] = 1'b1; nclk(1);
      raw[0] = 1'b0; nclk(2);
      raw[0] = 1'b1; nclk(10);
      outs("bounce", 0, 0, 0, 0);

      // Reset during WAIT_HI with cnt=2, then full requalification.
      raw[0] = 1'b0;
      nclk(4);
      rstn[0] = 1'b0;
      nclk(1);
      rstn[0] = 1'b1;
      outs("wait_reset", 0, 0, 0, 0);
      nclk(5);
      outs("requal_early", 0, 0, 0, 0);
      nclk(1);
      outs("requal_commit", 0, 1, 1, 0);
      raw[0] = 1'b1;
      nclk(10);

      // Non-inverting, STABLE_CYCLES=2: commit at posedge k+3.
      raw[1] = 1'b1;
      nclk(3);
      outs("b_press_early", 1, 0, 0, 0);
      nclk(1);
      outs("b_press_commit", 1, 1, 1, 0);
      nclk(2);
      raw[1] = 1'b0; nclk(1);
      raw[1] = 1'b1; nclk(8);
      outs("b_glitch", 1, 1, 0, 0);

      random_run(0, 80);
      random_run(1, 80);
      raw[0] = 1'b1; raw[1] = 1'b0;
      nclk(20);
      check("pending_events", 0, q0.size(), 0);
      check("pending_events", 1, q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
